// File: rtl/monitor_text_streamer_pkg.sv
// Shared constants and FSM encoding for the monitor text streamer.
// The monitor region is 16 character words of the unified memory, starting at word 495.
package monitor_text_streamer_pkg;

    localparam int MON_BASE  = 495;
    localparam int MON_CHARS = 16;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;

    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } state_t;

endpackage

// File: rtl/monitor_text_streamer_shadow_regs.sv
// Shadow copy of the monitor region, built by snooping the CPU memory write bus.
// The dirty flag marks that the shadow has changed since the last frame snapshot.
module monitor_shadow_regs #(
    parameter int MON_BASE  = monitor_text_streamer_pkg::MON_BASE,
    parameter int MON_CHARS = monitor_text_streamer_pkg::MON_CHARS,
    parameter int ADDR_W    = monitor_text_streamer_pkg::ADDR_W,
    parameter int DATA_W    = monitor_text_streamer_pkg::DATA_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [ADDR_W-1:0]          addr,
    input  logic [DATA_W-1:0]          write_data,
    input  logic                       mem_write,
    input  logic                       clear_dirty,
    output logic [MON_CHARS-1:0][7:0]  shadow,
    output logic                       dirty
);
    import monitor_text_streamer_pkg::*;

    localparam int IDX_W = $clog2(MON_CHARS);

    logic [ADDR_W-1:0] offset;
    logic              hit;

    // Addresses below the base wrap to huge offsets, so one unsigned compare covers both bounds.
    assign offset = addr - ADDR_W'(MON_BASE);
    assign hit    = mem_write && (offset < ADDR_W'(MON_CHARS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= {MON_CHARS{ASCII_SPACE}};
            dirty  <= 1'b1;
        end else begin
            if (hit) begin
                shadow[offset[IDX_W-1:0]] <= write_data[7:0];
                dirty                     <= 1'b1;
            end else if (clear_dirty) begin
                dirty <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/monitor_text_streamer.sv
// Streams a 16-character snapshot of the memory-mapped monitor region to a valid/ready sink
// whenever the snooped shadow changes.
module monitor_text_streamer #(
    parameter int MON_BASE  = monitor_text_streamer_pkg::MON_BASE,
    parameter int MON_CHARS = monitor_text_streamer_pkg::MON_CHARS,
    parameter int ADDR_W    = monitor_text_streamer_pkg::ADDR_W,
    parameter int DATA_W    = monitor_text_streamer_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic              MemWrite,
    output logic [7:0]        char_data,
    output logic              char_valid,
    input  logic              char_ready,
    output logic              char_first,
    output logic              char_last,
    output logic              busy,
    output logic [15:0]       frame_count
);
    import monitor_text_streamer_pkg::*;

    localparam int               IDX_W    = $clog2(MON_CHARS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MON_CHARS - 1);

    state_t                     state;
    logic [MON_CHARS-1:0][7:0]  shadow;
    logic [MON_CHARS-1:0][7:0]  frame;
    logic                       dirty;
    logic [IDX_W-1:0]           idx;
    logic [IDX_W-1:0]           next_idx;
    logic                       clear_dirty;

    assign clear_dirty = (state == ST_LOAD);
    assign next_idx    = idx + 1'b1;

    monitor_shadow_regs #(
        .MON_BASE  (MON_BASE),
        .MON_CHARS (MON_CHARS),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W)
    ) u_shadow (
        .clk         (clk),
        .rst_n       (rst_n),
        .addr        (addr),
        .write_data  (write_data),
        .mem_write   (MemWrite),
        .clear_dirty (clear_dirty),
        .shadow      (shadow),
        .dirty       (dirty)
    );

    // The frame register is the atomic snapshot; shadow keeps absorbing writes while it is sent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            frame       <= '0;
            idx         <= '0;
            char_data   <= '0;
            char_valid  <= 1'b0;
            char_first  <= 1'b0;
            char_last   <= 1'b0;
            busy        <= 1'b0;
            frame_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (dirty) begin
                        state <= ST_LOAD;
                        busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    frame      <= shadow;
                    idx        <= '0;
                    char_data  <= shadow[0];
                    char_valid <= 1'b1;
                    char_first <= 1'b1;
                    char_last  <= 1'b0;
                    state      <= ST_SEND;
                end
                ST_SEND: begin
                    if (char_ready) begin
                        if (idx == LAST_IDX) begin
                            char_valid  <= 1'b0;
                            char_first  <= 1'b0;
                            char_last   <= 1'b0;
                            busy        <= 1'b0;
                            frame_count <= frame_count + 16'd1;
                            state       <= ST_IDLE;
                        end else begin
                            idx        <= next_idx;
                            char_data  <= frame[next_idx];
                            char_first <= 1'b0;
                            char_last  <= (next_idx == LAST_IDX);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_monitor_text_streamer.sv
// Self-checking bench: directed sequences, a vector table for snoop decode, and random traffic
// scored against a snapshot-based model of the monitor region.
module tb_monitor_text_streamer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] write_data = '0;
    logic        mem_write = 1'b0;
    logic        char_ready = 1'b0;
    logic [7:0]  char_data;
    logic        char_valid;
    logic        char_first;
    logic        char_last;
    logic        busy;
    logic [15:0] frame_count;

    always #5 clk = ~clk;

    monitor_text_streamer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .addr        (addr),
        .write_data  (write_data),
        .MemWrite    (mem_write),
        .char_data   (char_data),
        .char_valid  (char_valid),
        .char_ready  (char_ready),
        .char_first  (char_first),
        .char_last   (char_last),
        .busy        (busy),
        .frame_count (frame_count)
    );

    typedef struct {
        logic [31:0] a;
        logic        we;
        logic [31:0] d;
        int          nframes;
    } vec_t;

    vec_t vecs[8];

    int total = 0;
    int bad = 0;

    byte unsigned mshadow[16];
    byte unsigned snap[16];
    byte unsigned exp_frame[16];
    byte unsigned rx_cur[16];
    byte unsigned rx_last[16];
    byte unsigned rx_prev[16];
    bit           mdirty;
    bit           in_frame;
    bit           wrote;
    bit           stalled;
    int           beat;
    int           mframes;
    logic [7:0]   st_data;
    logic         st_first;
    logic         st_last;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic bit in_region(input logic [31:0] a);
        return (a >= 32'd495) && (a < 32'd511);
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 16; i++) begin
            mshadow[i] = 8'h20;
            snap[i]    = 8'h20;
        end
        mdirty   = 1'b1;
        in_frame = 1'b0;
        wrote    = 1'b0;
        stalled  = 1'b0;
        beat     = 0;
        mframes  = 0;
    endtask

    // A frame must carry the shadow as it stood just before the edge that loaded it.
    task automatic monitorLoop();
        modelReset();
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                modelReset();
            end else begin
                if (char_valid && !in_frame) begin
                    checkOutput("frame_without_change", mdirty, 1);
                    exp_frame = snap;
                    in_frame  = 1'b1;
                    beat      = 0;
                    if (!wrote) mdirty = 1'b0;
                end
                if (stalled) begin
                    checkOutput("stall_valid", char_valid, 1);
                    checkOutput("stall_data", char_data, st_data);
                    checkOutput("stall_first", char_first, st_first);
                    checkOutput("stall_last", char_last, st_last);
                end
                if (char_valid) checkOutput("busy_while_valid", busy, 1);
                if (char_valid && char_ready) begin
                    checkOutput("beat_data", char_data, exp_frame[beat]);
                    checkOutput("beat_first", char_first, beat == 0);
                    checkOutput("beat_last", char_last, beat == 15);
                    rx_cur[beat] = char_data;
                    if (beat == 15) begin
                        in_frame = 1'b0;
                        mframes++;
                        rx_prev = rx_last;
                        rx_last = rx_cur;
                        beat = 0;
                    end else begin
                        beat++;
                    end
                end
                stalled  = char_valid && !char_ready;
                st_data  = char_data;
                st_first = char_first;
                st_last  = char_last;
                snap  = mshadow;
                wrote = 1'b0;
                if (mem_write && in_region(addr)) begin
                    mshadow[addr - 32'd495] = write_data[7:0];
                    mdirty = 1'b1;
                    wrote  = 1'b1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic we, input logic [31:0] d);
        addr       = a;
        mem_write  = we;
        write_data = d;
        tick();
        mem_write  = 1'b0;
    endtask

    task automatic waitIdle(input int budget, input string name);
        int n = 0;
        while ((busy || char_valid || mdirty) && n < budget) begin
            tick();
            n++;
        end
        checkOutput(name, busy || char_valid || mdirty, 0);
    endtask

    task automatic waitBeat(input int b);
        int n = 0;
        while (!(char_valid && beat == b) && n < 200) begin
            tick();
            n++;
        end
        checkOutput("reach_beat", char_valid && beat == b, 1);
    endtask

    initial begin
        logic [15:0] fc;
        logic [15:0] diff;

        vecs[0] = '{32'd494,        1'b1, 32'h41,        0};
        vecs[1] = '{32'd511,        1'b1, 32'h42,        0};
        vecs[2] = '{32'd500,        1'b0, 32'h43,        0};
        vecs[3] = '{32'd0,          1'b1, 32'h44,        0};
        vecs[4] = '{32'h8000_01F4,  1'b1, 32'h45,        0};
        vecs[5] = '{32'd495,        1'b1, 32'hABCD_EF31, 1};
        vecs[6] = '{32'd510,        1'b1, 32'h7A,        1};
        vecs[7] = '{32'd510,        1'b1, 32'h7A,        1};

        fork
            monitorLoop();
        join_none

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_valid", char_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_count", frame_count, 0);
        checkOutput("rst_data", char_data, 0);
        checkOutput("rst_first", char_first, 0);
        checkOutput("rst_last", char_last, 0);
        rst_n      = 1'b1;
        char_ready = 1'b1;

        waitIdle(100, "boot_idle");
        checkOutput("boot_count", frame_count, 1);
        for (int i = 0; i < 16; i++) checkOutput("boot_char", rx_last[i], 8'h20);

        // Back-to-back writes: the third lands on the snapshot edge, forcing a follow-up frame.
        fc = frame_count;
        applyStimulus(32'd495, 1'b1, 32'h77);
        checkOutput("lat_e0_valid", char_valid, 0);
        addr = 32'd496; write_data = 32'h65; mem_write = 1'b1;
        tick();
        checkOutput("lat_e1_valid", char_valid, 0);
        checkOutput("lat_e1_busy", busy, 1);
        addr = 32'd497; write_data = 32'h6C;
        tick();
        mem_write = 1'b0;
        checkOutput("lat_e2_valid", char_valid, 1);
        checkOutput("lat_e2_first", char_first, 1);
        checkOutput("lat_e2_data", char_data, 8'h77);
        waitIdle(200, "wel_idle");
        diff = frame_count - fc;
        checkOutput("wel_frames", diff, 2);
        checkOutput("we_char1", rx_prev[1], 8'h65);
        checkOutput("we_char2", rx_prev[2], 8'h20);
        checkOutput("wel_char0", rx_last[0], 8'h77);
        checkOutput("wel_char2", rx_last[2], 8'h6C);
        checkOutput("wel_char3", rx_last[3], 8'h20);

        fc = frame_count;
        applyStimulus(32'd498, 1'b1, 32'h21);
        waitBeat(3);
        char_ready = 1'b0;
        repeat (5) begin
            tick();
            checkOutput("hold_valid", char_valid, 1);
            checkOutput("hold_data", char_data, 8'h21);
            checkOutput("hold_last", char_last, 0);
        end
        char_ready = 1'b1;
        waitIdle(200, "stall_idle");
        diff = frame_count - fc;
        checkOutput("stall_frames", diff, 1);
        checkOutput("stall_char3", rx_last[3], 8'h21);

        fc = frame_count;
        applyStimulus(32'd496, 1'b1, 32'h45);
        waitBeat(2);
        applyStimulus(32'd500, 1'b1, 32'h41);
        waitBeat(15);
        tick();
        checkOutput("b2b_gap0_valid", char_valid, 0);
        tick();
        checkOutput("b2b_gap1_valid", char_valid, 0);
        checkOutput("b2b_gap1_busy", busy, 1);
        tick();
        checkOutput("b2b_next_valid", char_valid, 1);
        checkOutput("b2b_next_first", char_first, 1);
        waitIdle(200, "b2b_idle");
        diff = frame_count - fc;
        checkOutput("midwrite_frames", diff, 2);
        checkOutput("midwrite_old5", rx_prev[5], 8'h20);
        checkOutput("midwrite_old1", rx_prev[1], 8'h45);
        checkOutput("midwrite_new5", rx_last[5], 8'h41);

        for (int i = 0; i < 8; i++) begin
            fc = frame_count;
            applyStimulus(vecs[i].a, vecs[i].we, vecs[i].d);
            repeat (4) tick();
            waitIdle(200, $sformatf("vec%0d_idle", i));
            diff = frame_count - fc;
            checkOutput($sformatf("vec%0d_frames", i), diff, vecs[i].nframes);
        end
        checkOutput("vec_lowbyte", rx_last[0], 8'h31);
        checkOutput("vec_char15", rx_last[15], 8'h7A);

        applyStimulus(32'd505, 1'b1, 32'h52);
        waitBeat(7);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_valid", char_valid, 0);
        checkOutput("arst_busy", busy, 0);
        checkOutput("arst_count", frame_count, 0);
        checkOutput("arst_first", char_first, 0);
        checkOutput("arst_data", char_data, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        waitIdle(200, "arst_idle");
        checkOutput("arst_frames", frame_count, 1);
        checkOutput("arst_char10", rx_last[10], 8'h20);
        checkOutput("arst_char0", rx_last[0], 8'h20);

        repeat (1500) begin
            char_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) begin
                addr      = 32'd490 + $urandom_range(0, 25);
                mem_write = 1'b1;
            end else begin
                addr      = $urandom;
                mem_write = $urandom_range(0, 1) == 1;
            end
            write_data = $urandom;
            tick();
        end
        mem_write  = 1'b0;
        char_ready = 1'b1;
        waitIdle(2000, "rand_idle");
        checkOutput("rand_count", frame_count, mframes[15:0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
